// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master state encoding and
// default bus widths.
package axi4_lite_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_DATA = 3'd4,
    WR_RESP = 3'd5,
    RSP     = 3'd6
  } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// Command-driven AXI4-Lite master: one read or write at a time, with AW
// issued before W, and the slave response returned on a valid/ready port.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_write,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,

  output logic                ARVALID,
  input  logic                ARREADY,
  output logic [ADDR_W-1:0]   ARADDR,
  input  logic                RVALID,
  output logic                RREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,

  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic                WVALID,
  input  logic                WREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  input  logic                BVALID,
  output logic                BREADY,
  input  logic [1:0]          BRESP
);

  state_t              state;
  state_t              state_next;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                write_q;
  logic [1:0]          resp_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = cmd_write ? WR_ADDR : RD_ADDR;
      RD_ADDR: if (ARREADY)   state_next = RD_DATA;
      RD_DATA: if (RVALID)    state_next = RSP;
      WR_ADDR: if (AWREADY)   state_next = WR_DATA;
      WR_DATA: if (WREADY)    state_next = WR_RESP;
      WR_RESP: if (BVALID)    state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Command and response registers; RVALID/BVALID only sampled in their own states.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      resp_q  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          addr_q  <= cmd_addr;
          wdata_q <= cmd_wdata;
          write_q <= cmd_write;
        end
        RD_DATA: if (RVALID) begin
          rdata_q <= RDATA;
          resp_q  <= RRESP;
        end
        WR_RESP: if (BVALID) begin
          rdata_q <= '0;
          resp_q  <= BRESP;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      RD_ADDR: ARVALID   = 1'b1;
      RD_DATA: RREADY    = 1'b1;
      WR_ADDR: AWVALID   = 1'b1;
      WR_DATA: WVALID    = 1'b1;
      WR_RESP: BREADY    = 1'b1;
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign ARADDR    = addr_q;
  assign AWADDR    = addr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = '1;
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Scoreboard bench for axi4_lite_master with a behavioural AXI4-Lite slave
// whose per-channel wait cycles and response codes are set by the stimulus.
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [7:0]  ARADDR;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [7:0]  AWADDR;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;

  axi4_lite_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lat;
    int          aww;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Slave model configuration
  int unsigned ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0]  r_resp = RESP_OKAY, b_resp = RESP_OKAY;
  logic [31:0] mem [256];

  initial begin
    int unsigned ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic [7:0]  rd_addr, wr_addr;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    rd_addr = '0; wr_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'hDEADBEEF;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
    forever begin
      @(posedge clk); #1;
      if (ARVALID && ar_cnt >= ar_wait) begin
        ARREADY = 1; rd_addr = ARADDR; ar_cnt = 0;
      end else begin
        ARREADY = 0; ar_cnt = ARVALID ? ar_cnt + 1 : 0;
      end
      if (RREADY && r_cnt >= r_wait) begin
        RVALID = 1; RDATA = mem[rd_addr]; RRESP = r_resp; r_cnt = 0;
      end else begin
        RVALID = 0; RDATA = '0; r_cnt = RREADY ? r_cnt + 1 : 0;
      end
      if (AWVALID && aw_cnt >= aw_wait) begin
        AWREADY = 1; wr_addr = AWADDR; aw_cnt = 0;
      end else begin
        AWREADY = 0; aw_cnt = AWVALID ? aw_cnt + 1 : 0;
      end
      if (WVALID && w_cnt >= w_wait) begin
        WREADY = 1; mem[wr_addr] = WDATA; w_cnt = 0;
      end else begin
        WREADY = 0; w_cnt = WVALID ? w_cnt + 1 : 0;
      end
      if (BREADY && b_cnt >= b_wait) begin
        BVALID = 1; BRESP = b_resp; b_cnt = 0;
      end else begin
        BVALID = 0; b_cnt = BREADY ? b_cnt + 1 : 0;
      end
    end
  end

  // Monitor: cycle k after command acceptance is seen with cyc == acc_cyc + k
  int   cyc = 0;
  int   acc_cyc = 0;
  logic ar_prev = 0, aw_prev = 0, w_prev = 0, rv_prev = 0;
  exp_t e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ar_prev = 0; aw_prev = 0; w_prev = 0; rv_prev = 0;
    end else begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (sb.size() > 0) begin
        e = sb[0];
        if (ARVALID) begin
          if (!ar_prev) check("ar_cycle", 32'(cyc - acc_cyc), 32'd1);
          check("araddr", 32'(ARADDR), 32'(e.addr));
        end
        if (AWVALID) begin
          if (!aw_prev) begin
            check("aw_cycle", 32'(cyc - acc_cyc), 32'd1);
            check("wvalid_during_aw", 32'(WVALID), 32'd0);
          end
          check("awaddr", 32'(AWADDR), 32'(e.addr));
        end
        if (WVALID) begin
          if (!w_prev) check("w_cycle", 32'(cyc - acc_cyc), 32'(2 + e.aww));
          check("wdata", WDATA, e.wdata);
          check("wstrb", 32'(WSTRB), 32'hF);
        end
        if (rsp_valid) begin
          if (!rv_prev) check("rsp_latency", 32'(cyc - acc_cyc), 32'(e.lat));
          check("rsp_write", 32'(rsp_write), 32'(e.write));
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("rsp_resp", 32'(rsp_resp), 32'(e.resp));
          if (!rsp_ready) check("cmd_ready_while_rsp", 32'(cmd_ready), 32'd0);
          else void'(sb.pop_front());
        end
      end else if (rsp_valid) begin
        check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
      end
      ar_prev = ARVALID; aw_prev = AWVALID; w_prev = WVALID;
      rv_prev = rsp_valid && !rsp_ready;
    end
  end

  // Pushes the expected response, then holds the command until accepted.
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] er, input logic [1:0] eresp,
                        input int lat, input int aww);
    logic ok;
    exp_t x;
    x.write = wr; x.addr = a; x.wdata = d; x.rdata = er; x.resp = eresp;
    x.lat = lat; x.aww = aww;
    sb.push_back(x);
    ok = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      ok = cmd_ready;
      @(posedge clk); #1;
    end
    cmd_valid = 0;
    check("cmd_accepted", 32'(ok), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1;
    repeat (3) begin @(posedge clk); #1; end
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_fields", {rsp_rdata[29:0], rsp_write, 1'b0} | 32'(rsp_resp), 32'd0);
    check("rst_valid_ready", 32'({ARVALID, RREADY, AWVALID, WVALID, BREADY}), 32'd0);
    check("rst_addrs", 32'({ARADDR, AWADDR}), 32'd0);
    check("rst_wdata", WDATA, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    do_cmd(0, 8'h10, 32'h0, 32'hDEADBEEF, RESP_OKAY, 3, 0);
    do_cmd(1, 8'h04, 32'h12345678, 32'h0, RESP_OKAY, 4, 0);
    do_cmd(0, 8'h04, 32'h0, 32'h12345678, RESP_OKAY, 3, 0);

    aw_wait = 3;
    do_cmd(1, 8'h08, 32'hA5A50F0F, 32'h0, RESP_OKAY, 7, 3);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin @(posedge clk); #1; end
    aw_wait = 0;

    rsp_ready = 0;
    do_cmd(0, 8'h08, 32'h0, 32'hA5A50F0F, RESP_OKAY, 3, 0);
    fork
      do_cmd(0, 8'h10, 32'h0, 32'hDEADBEEF, RESP_OKAY, 3, 0);
      begin
        for (int i = 0; i < 20 && !rsp_valid; i++) begin @(posedge clk); #1; end
        check("hold_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) begin @(posedge clk); #1; end
        rsp_ready = 1;
      end
    join

    // Abandon a write stalled in WR_DATA
    w_wait = 5;
    do_cmd(1, 8'h0C, 32'h11112222, 32'h0, RESP_OKAY, 4, 0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (WVALID) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("reset_test_wvalid_seen", 32'(seen), 32'd1);
    rst = 1;
    sb.delete();
    @(posedge clk); #1;
    rst = 0;
    check("rst_wr_wvalid", 32'(WVALID), 32'd0);
    check("rst_wr_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_rsp_valid", 32'(rsp_valid), 32'd0);
    w_wait = 0;
    do_cmd(0, 8'h10, 32'h0, 32'hDEADBEEF, RESP_OKAY, 3, 0);
    do_cmd(0, 8'h0C, 32'h0, 32'h00000000, RESP_OKAY, 3, 0);

    b_resp = RESP_SLVERR;
    do_cmd(1, 8'h20, 32'hCAFEF00D, 32'h0, RESP_SLVERR, 4, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin @(posedge clk); #1; end
    b_resp = RESP_OKAY;
    do_cmd(1, 8'h14, 32'h0BADCAFE, 32'h0, RESP_OKAY, 4, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) begin @(posedge clk); #1; end
    r_resp = RESP_DECERR; r_wait = 2;
    do_cmd(0, 8'h14, 32'h0, 32'h0BADCAFE, RESP_DECERR, 5, 0);

    for (int i = 0; i < 50 && sb.size() > 0; i++) begin @(posedge clk); #1; end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    r_resp = RESP_OKAY; r_wait = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

Command-driven AXI4-Lite master that sits directly upstream of the AXI4-Lite slave FSM/RAM block. It accepts single read or write requests on a simple valid/ready command port. It sequences the AR/R or AW/W/B handshakes one transaction at a time, and returns read data plus response code on a valid/ready response port. It issues write address before write data, matching the slave, which only raises WREADY after the AW handshake.

## Interface
- ADDR_W, 8, address width
- DATA_W, 32, data width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  request present
- cmd_ready  out  1  request accepted when both high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_write  out  1  response belongs to a write
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_resp  out  2  RRESP or BRESP as returned
- ARVALID/ARADDR, RREADY/RDATA/RRESP, AWVALID/AWADDR, WVALID/WDATA/WSTRB, BREADY/BRESP: AXI4-Lite master side; widths ADDR_W / DATA_W / DATA_W/8 / 2

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, RSP.
- IDLE: cmd_ready = 1. On cmd_valid, latch addr, wdata, and write into registers. Go to WR_ADDR if write, else RD_ADDR.
- RD_ADDR: ARVALID = 1 and ARADDR = latched addr. On ARREADY, go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID, capture RDATA and RRESP, then go to RSP.
- WR_ADDR: AWVALID = 1. On AWREADY, go to WR_DATA. WVALID stays 0 in this state.
- WR_DATA: WVALID = 1, WDATA = latched data, WSTRB all ones. On WREADY, go to WR_RESP.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP, set rdata to 0, then go to RSP.
- RSP: rsp_valid = 1. On rsp_ready, go to IDLE.
- Only one transaction is outstanding at a time. cmd_ready is 0 in every state except IDLE.
- All VALID outputs, addresses, and data stay stable until their handshake completes. They never drop before READY.
- Responses pass through unmodified. SLVERR and DECERR are not retried.
- Undefined state encodings go to IDLE on the next clock.

## Timing
- All outputs are decoded from registered state and registers. There is no combinational input-to-output path except through state.
- Reset (any state, any cycle) forces IDLE on the next edge. Reset values:
  - cmd_ready = 1
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_resp = 0
  - all AXI VALID/READY outputs = 0, ARADDR/AWADDR/WDATA = 0
- Reset mid-transaction abandons the transaction with no response. The system resets the slave together with the master.
- Against a zero-wait slave, with the command accepted at edge 0:
  - Read: ARVALID in cycle 1, RREADY/R handshake in cycle 2, rsp_valid in cycle 3.
  - Write: AWVALID in cycle 1, WVALID in cycle 2, B handshake in cycle 3, rsp_valid in cycle 4.
- Each slave wait cycle adds exactly one cycle to the state it occurs in.
- rsp_ready held high: IDLE is re-entered the cycle after rsp_valid. Back-to-back throughput is 1 read per 4 cycles and 1 write per 5 cycles.
- RVALID or BVALID arriving earlier than expected is ignored outside RD_DATA / WR_RESP.

## Structure
- Shared package axi4_lite_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11
  - the master state enumeration (3 bits)
  - default ADDR_W and DATA_W
- Single flat module. No sub-module is needed.

## Test plan
- Read, zero-wait slave returning RDATA = 32'hDEADBEEF, RRESP = 0 at addr 8'h10 -> ARADDR = 8'h10 in cycle 1; rsp_valid in cycle 3 with rsp_rdata = 32'hDEADBEEF, rsp_resp = 0, rsp_write = 0.
- Write to addr 8'h04 with data 32'h12345678 against the slave FSM -> AWVALID in cycle 1 with WVALID = 0, WVALID in cycle 2 with WDATA = 32'h12345678, rsp_valid in cycle 4 with rsp_write = 1 and rsp_rdata = 0.
- Slave holds AWREADY low for 3 cycles -> AWVALID and AWADDR stay stable for those 3 cycles; rsp_valid arrives 3 cycles later than zero-wait.
- rsp_ready held low for 5 cycles after a read -> rsp_valid and rsp_rdata stay stable; cmd_ready stays 0; a new command is accepted only after rsp_ready.
- rst asserted in WR_DATA -> the next cycle has WVALID = 0, cmd_ready = 1, rsp_valid = 0; a subsequent read completes normally.
- BRESP = 2'b10 returned -> rsp_resp = 2'b10 with no retry; the next command is accepted.
